// File: rtl/photon_stream_serializer_if.sv
// Record-input and word-stream bus of photon_stream_serializer.
// slave is the serializer's view, master is the pipeline/host side.
interface photon_stream_serializer_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               i_valid;
    logic               o_in_ready;
    logic [31:0]        i_x;
    logic [31:0]        i_y;
    logic [31:0]        i_z;
    logic [31:0]        i_ux;
    logic [31:0]        i_uy;
    logic [31:0]        i_uz;
    logic [31:0]        i_sz;
    logic [31:0]        i_sr;
    logic [31:0]        i_sleftz;
    logic [31:0]        i_sleftr;
    logic [31:0]        i_weight;
    logic [2:0]         i_layer;
    logic               i_dead;
    logic               i_hit;
    logic [31:0]        o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_last;
    logic [3:0]         o_index;
    logic [COUNT_W-1:0] o_count;

    modport slave (
        input  i_valid, i_x, i_y, i_z, i_ux, i_uy, i_uz, i_sz, i_sr,
               i_sleftz, i_sleftr, i_weight, i_layer, i_dead, i_hit, i_ready,
        output o_in_ready, o_data, o_valid, o_last, o_index, o_count
    );

    modport master (
        output i_valid, i_x, i_y, i_z, i_ux, i_uy, i_uz, i_sz, i_sr,
               i_sleftz, i_sleftr, i_weight, i_layer, i_dead, i_hit, i_ready,
        input  o_in_ready, o_data, o_valid, o_last, o_index, o_count
    );
endinterface

// File: rtl/photon_stream_serializer.sv
// Drains one photon record at a time into a shadow buffer and streams it as 32-bit words.
// Optional macro PHOTON_SER_CHECKSUM_EN appends an XOR checksum word (13 words per record).
module photon_stream_serializer #(
    parameter bit          DROP_DEAD = 1'b1,
    parameter int unsigned COUNT_W   = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    photon_stream_serializer_if.slave   bus
);
    localparam int unsigned NREC = 12;
`ifdef PHOTON_SER_CHECKSUM_EN
    localparam int unsigned NWORDS = 13;
`else
    localparam int unsigned NWORDS = 12;
`endif
    localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [3:0]         index_q, index_d;
    logic [31:0]        data_q, data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        buf_q [NREC];
    logic [31:0]        in_words [NREC];
    logic [31:0]        next_word_c;
    logic [3:0]         next_idx_c;
    logic               in_ready_c;
    logic               accept_c;
    logic               load_c;
    logic               xfer_c;
    logic               done_c;

    // Record fields in transmit order
    always_comb begin
        in_words[0]  = bus.i_x;
        in_words[1]  = bus.i_y;
        in_words[2]  = bus.i_z;
        in_words[3]  = bus.i_ux;
        in_words[4]  = bus.i_uy;
        in_words[5]  = bus.i_uz;
        in_words[6]  = bus.i_sz;
        in_words[7]  = bus.i_sr;
        in_words[8]  = bus.i_sleftz;
        in_words[9]  = bus.i_sleftr;
        in_words[10] = bus.i_weight;
        in_words[11] = {27'b0, bus.i_hit, bus.i_dead, bus.i_layer};
    end

    // Ready also on the final-word transfer so consecutive records need no bubble
    assign in_ready_c = !reset && ((state_q == S_IDLE) || (valid_q && bus.i_ready && last_q));
    assign accept_c   = in_ready_c && bus.i_valid;
    assign load_c     = accept_c && !(DROP_DEAD && bus.i_dead);
    assign xfer_c     = valid_q && bus.i_ready;
    assign done_c     = xfer_c && last_q;
    assign next_idx_c = index_q + 4'd1;

`ifdef PHOTON_SER_CHECKSUM_EN
    logic [31:0] csum_q;
    logic [31:0] in_xor_c;

    // Checksum is formed once at record load from the same fields that get buffered
    always_comb begin
        in_xor_c = '0;
        for (int i = 0; i < NREC; i++) in_xor_c = in_xor_c ^ in_words[i];
    end

    always_ff @(posedge clock) begin
        if (load_c) csum_q <= in_xor_c;
    end

    always_comb begin
        if (next_idx_c < 4'(NREC)) next_word_c = buf_q[next_idx_c];
        else                       next_word_c = csum_q;
    end
`else
    always_comb begin
        if (next_idx_c < 4'(NREC)) next_word_c = buf_q[next_idx_c];
        else                       next_word_c = '0;
    end
`endif

    always_ff @(posedge clock) begin
        if (load_c) buf_q <= in_words;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        index_d = index_q;
        data_d  = data_q;
        count_d = count_q;
        if (done_c) count_d = count_q + COUNT_W'(1);
        if (load_c) begin
            state_d = S_SEND;
            valid_d = 1'b1;
            index_d = 4'd0;
            last_d  = 1'b0;
            data_d  = bus.i_x;
        end else if (done_c) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            index_d = 4'd0;
            last_d  = 1'b0;
            data_d  = '0;
        end else if (xfer_c) begin
            index_d = next_idx_c;
            data_d  = next_word_c;
            last_d  = (next_idx_c == LAST_IDX);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            index_q <= 4'd0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            index_q <= index_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign bus.o_in_ready = in_ready_c;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;
    assign bus.o_index    = index_q;
    assign bus.o_data     = data_q;
    assign bus.o_count    = count_q;
endmodule

// File: tb/tb_photon_stream_serializer.sv
// Self-checking bench for photon_stream_serializer: directed scenarios plus a
// randomized run scored against a word-queue reference model.
module tb_photon_stream_serializer;
    localparam int unsigned COUNT_W   = 32;
    localparam bit          DROP_DEAD = 1'b1;
`ifdef PHOTON_SER_CHECKSUM_EN
    localparam int NW = 13;
`else
    localparam int NW = 12;
`endif

    typedef struct packed {
        logic [10:0][31:0] f;
        logic [2:0]        layer;
        logic              dead;
        logic              hit;
    } rec_t;

    logic               clock;
    logic               reset;
    int                 checks;
    int                 errors;
    logic [COUNT_W-1:0] m_count;

    photon_stream_serializer_if #(.COUNT_W(COUNT_W)) bus ();

    photon_stream_serializer #(.DROP_DEAD(DROP_DEAD), .COUNT_W(COUNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Word w of a record as the host must see it
    function automatic logic [31:0] rec_word(rec_t r, int w);
        logic [31:0] st;
        logic [31:0] x;
        st = {27'b0, r.hit, r.dead, r.layer};
        if (w < 11) return r.f[w];
        if (w == 11) return st;
        x = st;
        for (int i = 0; i < 11; i++) x = x ^ r.f[i];
        return x;
    endfunction

    function automatic rec_t seq_rec();
        rec_t r;
        for (int i = 0; i < 11; i++) r.f[i] = 32'(i + 1);
        r.layer = 3'd3;
        r.dead  = 1'b0;
        r.hit   = 1'b1;
        return r;
    endfunction

    function automatic rec_t rand_rec(logic dead);
        rec_t r;
        for (int i = 0; i < 11; i++) r.f[i] = $urandom;
        r.layer = 3'($urandom_range(0, 7));
        r.dead  = dead;
        r.hit   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    task automatic drive_rec(rec_t r);
        bus.i_x      = r.f[0];
        bus.i_y      = r.f[1];
        bus.i_z      = r.f[2];
        bus.i_ux     = r.f[3];
        bus.i_uy     = r.f[4];
        bus.i_uz     = r.f[5];
        bus.i_sz     = r.f[6];
        bus.i_sr     = r.f[7];
        bus.i_sleftz = r.f[8];
        bus.i_sleftr = r.f[9];
        bus.i_weight = r.f[10];
        bus.i_layer  = r.layer;
        bus.i_dead   = r.dead;
        bus.i_hit    = r.hit;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_valid = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_in_ready, bus.o_last, bus.o_index, bus.o_data, bus.o_count} !==
            {1'b0, 1'b0, 1'b0, 4'd0, 32'd0, COUNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_state: valid=%b in_ready=%b last=%b index=%0d data=%h count=%0d, required all zero",
                     bus.o_valid, bus.o_in_ready, bus.o_last, bus.o_index, bus.o_data, bus.o_count);
        end
        tick();
        reset = 1'b0;
        m_count = '0;
        @(negedge clock);
        checks++;
        if (bus.o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", bus.o_in_ready);
        end
        tick();
    endtask

    task automatic test_single_record();
        rec_t r;
        r = seq_rec();
        drive_rec(r);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.o_in_ready, bus.o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL single_accept: in_ready=%b valid=%b required 1 0", bus.o_in_ready, bus.o_valid);
        end
        tick();
        bus.i_valid = 1'b0;
        for (int w = 0; w < NW; w++) begin
            @(negedge clock);
            checks++;
            if ({bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data} !==
                {1'b1, 4'(w), (w == NW - 1), (w == NW - 1), rec_word(r, w)}) begin
                errors++;
                $display("FAIL single_word%0d: valid=%b index=%0d last=%b in_ready=%b data=%h, required 1 %0d %b %b %h",
                         w, bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data,
                         w, (w == NW - 1), (w == NW - 1), rec_word(r, w));
            end
            if (w == 11) begin
                checks++;
                if (bus.o_data !== 32'h0000_0013) begin
                    errors++;
                    $display("FAIL single_status: data=%h required 00000013", bus.o_data);
                end
            end
            tick();
        end
        m_count = m_count + COUNT_W'(1);
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, m_count}) begin
            errors++;
            $display("FAIL single_done: valid=%b count=%0d, required 0 %0d", bus.o_valid, bus.o_count, m_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rec_t r;
        int   widx;
        r = seq_rec();
        drive_rec(r);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        widx = 0;
        for (int cyc = 1; cyc <= 2 * NW - 1; cyc++) begin
            bus.i_ready = 1'((cyc % 2) == 1);
            @(negedge clock);
            checks++;
            if ({bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data} !==
                {1'b1, 4'(widx), (widx == NW - 1), (widx == NW - 1) && bus.i_ready, rec_word(r, widx)}) begin
                errors++;
                $display("FAIL bp_cycle%0d: valid=%b index=%0d last=%b in_ready=%b data=%h, required word %0d data=%h",
                         cyc, bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data,
                         widx, rec_word(r, widx));
            end
            if (bus.i_ready) widx++;
            tick();
        end
        m_count = m_count + COUNT_W'(1);
        bus.i_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, m_count}) begin
            errors++;
            $display("FAIL bp_done: valid=%b count=%0d, required 0 %0d", bus.o_valid, bus.o_count, m_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        rec_t a, b, rr;
        int   ww;
        a = rand_rec(1'b0);
        b = rand_rec(1'b0);
        drive_rec(a);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        drive_rec(b);
        for (int w = 0; w < 2 * NW; w++) begin
            rr = (w < NW) ? a : b;
            ww = w % NW;
            @(negedge clock);
            checks++;
            if ({bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data} !==
                {1'b1, 4'(ww), (ww == NW - 1), (ww == NW - 1), rec_word(rr, ww)}) begin
                errors++;
                $display("FAIL b2b_word%0d: valid=%b index=%0d last=%b in_ready=%b data=%h, required 1 %0d %b %b %h",
                         w, bus.o_valid, bus.o_index, bus.o_last, bus.o_in_ready, bus.o_data,
                         ww, (ww == NW - 1), (ww == NW - 1), rec_word(rr, ww));
            end
            tick();
            if (w == NW - 1) bus.i_valid = 1'b0;
            if (ww == NW - 1) m_count = m_count + COUNT_W'(1);
        end
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, m_count}) begin
            errors++;
            $display("FAIL b2b_done: valid=%b count=%0d, required 0 %0d", bus.o_valid, bus.o_count, m_count);
        end
        tick();
    endtask

    task automatic test_drop_dead();
        rec_t d, l;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        m_count = '0;
        d = rand_rec(1'b1);
        d.layer = 3'd1;
        l = rand_rec(1'b0);
        drive_rec(d);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.o_in_ready, bus.o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL dead_accept: in_ready=%b valid=%b required 1 0", bus.o_in_ready, bus.o_valid);
        end
        tick();
        drive_rec(l);
        @(negedge clock);
        checks++;
        if ({bus.o_in_ready, bus.o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL dead_dropped: in_ready=%b valid=%b required 1 0", bus.o_in_ready, bus.o_valid);
        end
        tick();
        bus.i_valid = 1'b0;
        for (int w = 0; w < NW; w++) begin
            @(negedge clock);
            checks++;
            if ({bus.o_valid, bus.o_index, bus.o_last, bus.o_data} !==
                {1'b1, 4'(w), (w == NW - 1), rec_word(l, w)}) begin
                errors++;
                $display("FAIL dead_live_word%0d: valid=%b index=%0d last=%b data=%h, required 1 %0d %b %h",
                         w, bus.o_valid, bus.o_index, bus.o_last, bus.o_data, w, (w == NW - 1), rec_word(l, w));
            end
            tick();
        end
        m_count = m_count + COUNT_W'(1);
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_count} !== {1'b0, COUNT_W'(1)}) begin
            errors++;
            $display("FAIL dead_count: valid=%b count=%0d, required 0 1", bus.o_valid, bus.o_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_record();
        rec_t r;
        bit   found;
        r = rand_rec(1'b0);
        drive_rec(r);
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.o_valid && bus.o_index == 4'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach_word5: index=%0d valid=%b, word 5 required within 20 cycles",
                     bus.o_index, bus.o_valid);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready_forced: in_ready=%b required 0", bus.o_in_ready);
        end
        tick();
        @(negedge clock);
        checks++;
        if ({bus.o_valid, bus.o_count, bus.o_in_ready} !== {1'b0, COUNT_W'(0), 1'b0}) begin
            errors++;
            $display("FAIL midreset_cleared: valid=%b count=%0d in_ready=%b, required 0 0 0",
                     bus.o_valid, bus.o_count, bus.o_in_ready);
        end
        tick();
        reset = 1'b0;
        m_count = '0;
        @(negedge clock);
        checks++;
        if ({bus.o_in_ready, bus.o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL midreset_release: in_ready=%b valid=%b required 1 0", bus.o_in_ready, bus.o_valid);
        end
        tick();
    endtask

    // Random traffic: model is a FIFO of the words still owed to the host
    task automatic test_random();
        localparam int NCYC = 3000;
        logic [36:0] exp_q [$];
        logic [36:0] e;
        rec_t        cur;
        logic        exp_valid, exp_inr, accepted;
        cur = rand_rec(1'($urandom_range(0, 3) == 0));
        drive_rec(cur);
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_ready = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock);
            exp_valid = (exp_q.size() != 0);
            exp_inr   = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.i_ready);
            checks++;
            if ({bus.o_valid, bus.o_in_ready, bus.o_count} !== {exp_valid, exp_inr, m_count}) begin
                errors++;
                $display("FAIL rand_ctrl cyc%0d: valid=%b in_ready=%b count=%0d, required %b %b %0d",
                         cyc, bus.o_valid, bus.o_in_ready, bus.o_count, exp_valid, exp_inr, m_count);
            end
            if (exp_valid && bus.i_ready) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.o_index, bus.o_last, bus.o_data} !== e) begin
                    errors++;
                    $display("FAIL rand_word cyc%0d: index=%0d last=%b data=%h, required %0d %b %h",
                             cyc, bus.o_index, bus.o_last, bus.o_data, e[36:33], e[32], e[31:0]);
                end
                if (e[32]) m_count = m_count + COUNT_W'(1);
            end
            accepted = exp_inr && bus.i_valid;
            if (accepted && (!cur.dead || !DROP_DEAD)) begin
                for (int w = 0; w < NW; w++) exp_q.push_back({4'(w), (w == NW - 1), rec_word(cur, w)});
            end
            tick();
            if (accepted || !bus.i_valid) begin
                cur = rand_rec(1'($urandom_range(0, 3) == 0));
                drive_rec(cur);
                bus.i_valid = 1'($urandom_range(0, 1));
            end
            bus.i_ready = 1'($urandom_range(0, 3) != 0);
            if (cyc > NCYC - 40) begin
                bus.i_valid = 1'b0;
                bus.i_ready = 1'b1;
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_count = '0;
        reset = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        drive_rec(seq_rec());
        test_reset();
        test_single_record();
        test_backpressure();
        test_back_to_back();
        test_drop_dead();
        test_reset_mid_record();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
